// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the issue stage, its instruction source
// and the ALU it feeds.
interface alu_issue_stage_if #(
  parameter int CNT_W = 16
);
  logic             IN_VLD;
  logic             IN_RDY;
  logic [31:0]      INSTR;
  logic [31:0]      PC;
  logic [31:0]      RS1_VAL;
  logic [31:0]      RS2_VAL;
  logic             FLUSH;
  logic             OUT_VLD;
  logic             OUT_RDY;
  logic             EN;
  logic [4:0]       OPC;
  logic [31:0]      A;
  logic [31:0]      B;
  logic [4:0]       SHFT;
  logic             CIN;
  logic [4:0]       RD;
  logic             WE;
  logic             ILL;
  logic [CNT_W-1:0] ISSUE_CNT;

  modport master (
    output IN_VLD, INSTR, PC, RS1_VAL, RS2_VAL,
    output FLUSH, OUT_RDY,
    input  IN_RDY, OUT_VLD, EN, OPC, A, B, SHFT,
    input  CIN, RD, WE, ILL, ISSUE_CNT
  );

  modport slave (
    input  IN_VLD, INSTR, PC, RS1_VAL, RS2_VAL,
    input  FLUSH, OUT_RDY,
    output IN_RDY, OUT_VLD, EN, OPC, A, B, SHFT,
    output CIN, RD, WE, ILL, ISSUE_CNT
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I integer decode/issue stage feeding ALU_32bit, with a
// registered valid/ready output slot and an issued-instruction counter.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input logic              CLK,
  input logic              RST,
  alu_issue_stage_if.slave bus
);
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  typedef struct packed {
    logic [4:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shft;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } dec_t;

  function automatic logic [4:0] alu_fn(input logic [2:0] f3);
    logic [4:0] r;
    unique case (f3)
      3'd0:    r = ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  logic [6:0]       op;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [4:0]       rd;
  logic [4:0]       sham;
  logic [31:0]      imm_i;
  logic [31:0]      imm_u;
  logic             take;
  dec_t             dec;
  dec_t             q;
  logic             vld;
  logic [CNT_W-1:0] cnt;

  assign op    = bus.INSTR[6:0];
  assign f3    = bus.INSTR[14:12];
  assign f7    = bus.INSTR[31:25];
  assign rd    = bus.INSTR[11:7];
  assign sham  = bus.INSTR[24:20];
  assign imm_i = {{20{bus.INSTR[31]}}, bus.INSTR[31:20]};
  assign imm_u = {bus.INSTR[31:12], 12'b0};

  // Start from the illegal form; each legal path clears ill.
  always_comb begin
    dec     = '0;
    dec.ill = 1'b1;
    dec.rd  = rd;
    unique case (1'b1)
      (op == OP_R): begin
        if (f7 == 7'h00) begin
          dec.ill  = 1'b0;
          dec.opc  = alu_fn(f3);
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          dec.ill  = 1'b0;
          dec.opc  = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
        end
        if (!dec.ill) begin
          dec.a    = bus.RS1_VAL;
          dec.b    = bus.RS2_VAL;
          dec.shft = bus.RS2_VAL[4:0];
        end
      end
      (op == OP_I): begin
        if (f3 == 3'd1) begin
          if (f7 == 7'h00) begin
            dec.ill  = 1'b0;
            dec.opc  = ALU_SLL;
            dec.a    = bus.RS1_VAL;
            dec.b    = {27'b0, sham};
            dec.shft = sham;
          end
        end else if (f3 == 3'd5) begin
          if (f7 == 7'h00 || f7 == 7'h20) begin
            dec.ill  = 1'b0;
            dec.opc  = f7[5] ? ALU_SRA : ALU_SRL;
            dec.a    = bus.RS1_VAL;
            dec.b    = {27'b0, sham};
            dec.shft = sham;
          end
        end else begin
          dec.ill = 1'b0;
          dec.opc = alu_fn(f3);
          dec.a   = bus.RS1_VAL;
          dec.b   = imm_i;
        end
      end
      (op == OP_LUI): begin
        dec.ill = 1'b0;
        dec.b   = imm_u;
      end
      (op == OP_AUI): begin
        dec.ill = 1'b0;
        dec.a   = bus.PC;
        dec.b   = imm_u;
      end
      default: ;
    endcase
    dec.we = !dec.ill && (rd != 5'd0);
  end

  assign bus.IN_RDY = !bus.FLUSH && (!vld || bus.OUT_RDY);
  assign take       = bus.IN_VLD && bus.IN_RDY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld <= 1'b0;
      q   <= '0;
      cnt <= '0;
    end else begin
      if (bus.FLUSH) begin
        vld <= 1'b0;
      end else if (take) begin
        vld <= 1'b1;
        q   <= dec;
      end else if (bus.OUT_RDY) begin
        vld <= 1'b0;
      end
      if (vld && bus.OUT_RDY && !bus.FLUSH) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.OUT_VLD   = vld;
  assign bus.EN        = vld;
  assign bus.OPC       = q.opc;
  assign bus.A         = q.a;
  assign bus.B         = q.b;
  assign bus.SHFT      = q.shft;
  assign bus.CIN       = 1'b0;
  assign bus.RD        = q.rd;
  assign bus.WE        = q.we;
  assign bus.ILL       = q.ill;
  assign bus.ISSUE_CNT = cnt;
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue pipeline stage that sits directly upstream of `ALU_32bit`. It accepts one RV32I integer instruction per handshake, together with its PC and the already-read register operands. It decodes the instruction into the ALU's `OPC`/`A`/`B`/`SHFT`/`CIN`/`EN` controls and holds them in a registered output stage with valid/ready backpressure. It also carries the destination register and write-enable forward, flags illegal encodings, and counts issued instructions.

## Interface
- `CNT_W`, default 16: width of the issued-instruction counter.
- Clock and reset: one clock; reset is asynchronous and active-low. The clock port is `CLK` and the reset port is `RST`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: asynchronous active-low reset.
- `IN_VLD` in 1: upstream has an instruction.
- `IN_RDY` out 1: stage can accept; equals `!FLUSH && (!OUT_VLD || OUT_RDY)`.
- `INSTR` in 32: RV32I instruction word.
- `PC` in 32: instruction address.
- `RS1_VAL` in 32: value of `x[rs1]`.
- `RS2_VAL` in 32: value of `x[rs2]`.
- `FLUSH` in 1: synchronous kill of the held and incoming instruction.
- `OUT_VLD` out 1: output register holds a valid instruction.
- `OUT_RDY` in 1: downstream consumes the output this cycle.
- `EN` out 1: ALU enable; equals `OUT_VLD`.
- `OPC` out 5: ALU opcode.
- `A` out 32: ALU operand A.
- `B` out 32: ALU operand B.
- `SHFT` out 5: ALU shift amount.
- `CIN` out 1: ALU carry-in; always 0 in this stage.
- `RD` out 5: destination register index.
- `WE` out 1: register writeback enable.
- `ILL` out 1: illegal-instruction flag.
- `ISSUE_CNT` out `CNT_W`: count of instructions handed downstream.

## Operation
- ALU opcode encoding: ADD=00000, SUB=00001, AND=00010, OR=00011, XOR=00100, SLL=00101, SRL=00110, SRA=00111, SLT=01000, SLTU=01001.
- Accept occurs when `IN_VLD && IN_RDY`. The decode is combinational on the inputs; the result is loaded into the output register and `OUT_VLD` is set.
- OP (0110011): A=`RS1_VAL`, B=`RS2_VAL`, SHFT=`RS2_VAL[4:0]`. Mapping on funct7/funct3:
  - funct7=0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND for funct3 0–7.
  - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
- OP-IMM (0010011): A=`RS1_VAL`, B=sign-extended `INSTR[31:20]`. funct3 gives ADD/SLL/SLT/SLTU/XOR/SRx/OR/AND.
  - For funct3 001 and 101: SHFT=`INSTR[24:20]` and B=`{27'b0, INSTR[24:20]}`.
  - funct3 001 requires funct7=0000000.
  - funct3 101 requires funct7 0000000 (SRL) or 0100000 (SRA).
  - For non-shift OP-IMM, SHFT=0.
- LUI (0110111): OPC=ADD, A=0, B=`{INSTR[31:12], 12'b0}`.
- AUIPC (0010111): OPC=ADD, A=`PC`, B=`{INSTR[31:12], 12'b0}`.
- `RD`=`INSTR[11:7]`. `WE`=1 for legal instructions with `RD`≠0, else 0.
- Any other opcode or an illegal funct7 sets ILL=1, OPC=ADD, A=B=0, SHFT=0, WE=0. The instruction is still issued so downstream can trap.
- `FLUSH`=1 clears `OUT_VLD` at the next edge and forces `IN_RDY`=0, so no accept happens that cycle. Other output fields keep their last values.
- `ISSUE_CNT` increments by 1 on every `OUT_VLD && OUT_RDY && !FLUSH`. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (`RST`=0, asynchronous):
  - `OUT_VLD`=0, `EN`=0, `OPC`=00000, `A`=`B`=0, `SHFT`=0, `CIN`=0, `RD`=0, `WE`=0, `ILL`=0, `ISSUE_CNT`=0.
  - `IN_RDY`=0 while `FLUSH` is high, else 1.
  - Reset mid-transfer drops the held instruction.
- Latency: 1 cycle from the accept edge to `OUT_VLD`=1 with decoded fields.
- Throughput: 1 instruction/cycle when `OUT_RDY`=1. A consume and a new accept in the same cycle replace the register contents with no bubble.
- Backpressure: while `OUT_VLD && !OUT_RDY`, every output field holds stable and `IN_RDY`=0.
- Simultaneous `FLUSH` and `OUT_RDY`: the flush wins. The counter does not increment and the output is invalidated.
- Upstream must hold `INSTR`/`PC`/`RS*_VAL` stable while `IN_VLD && !IN_RDY`.

## Test plan
- **ADD:** reset, then `INSTR`=0x002081B3, `RS1_VAL`=5, `RS2_VAL`=4, `OUT_RDY`=1 → the next cycle shows `OUT_VLD`=1, `OPC`=00000, `A`=5, `B`=4, `RD`=3, `WE`=1, `ILL`=0; `ISSUE_CNT` then reads 1.
- **SUB and SRAI:**
  - `INSTR`=0x402081B3 → `OPC`=00001.
  - `INSTR`=0x40335293 with `RS1_VAL`=0xE0A000BB → `OPC`=00111, `SHFT`=3, `A`=0xE0A000BB, `B`=0x00000003, `RD`=5.
- **LUI and AUIPC:**
  - `INSTR`=0x123450B7 → `OPC`=00000, `A`=0, `B`=0x12345000, `RD`=1.
  - `INSTR`=0x12345097 with `PC`=0x00000100 → `A`=0x100, `B`=0x12345000.
- **Illegal encodings:**
  - `INSTR`=0x0000007F → `ILL`=1, `WE`=0, `A`=`B`=0.
  - `INSTR`=0x402091B3 (SLL with funct7=0100000) → `ILL`=1.
- **Backpressure:** issue two instructions back-to-back with `OUT_RDY`=0 for 3 cycles → the first stays stable, `IN_RDY`=0, `ISSUE_CNT` is unchanged. Raising `OUT_RDY` drains both in 2 cycles and the counter gains +2.
- **FLUSH and reset:**
  - `FLUSH` with `OUT_VLD`=1 and `OUT_RDY`=1 → `OUT_VLD`=0 next cycle and no count.
  - Asserting `RST`=0 mid-cycle immediately forces all outputs to their reset values.
